dm_access_ctrl: RTL and testbench

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

---
 rtl/proc_pkg.sv | 41 ++++
 rtl/dm_store_fmt.sv | 42 ++++
 rtl/dm_access_ctrl.sv | 135 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// ============================================================================
// Module  : proc_pkg
// Brief   : Shared types and funct3 codes for the data-memory access path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_REQ  = 2'd1,
        DM_WAIT = 2'd2,
        DM_DONE = 2'd3
    } dm_ctrl_state_t;

    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    // Store and load word/half codes coincide, so one check covers both.
    function automatic logic dm_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        if (funct3 == LOAD_LW)
            r = |addr_lo;
        else if ((funct3 == LOAD_LH) || (funct3 == LOAD_LHU))
            r = addr_lo[0];
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_store_fmt.sv
// ============================================================================
// Module  : dm_store_fmt
// Brief   : Combinational byte-enable and lane-replicated write-data builder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_store_fmt
    import proc_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_data;
        if (i_is_store) begin
            case (i_funct3)
                STORE_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_data[7:0]}};
                end
                STORE_SH: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_data[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_data;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_access_ctrl.sv
// ============================================================================
// Module  : dm_access_ctrl
// Brief   : Memory-stage data-memory request/response sequencer.
//           Optional misaligned trap: define DM_MISALIGN_TRAP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_access_ctrl
    import proc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m_valid_i,
    input  logic        m_is_load_i,
    input  logic        m_is_store_i,
    input  logic [2:0]  m_funct3_i,
    input  logic [31:0] m_addr_i,
    input  logic [31:0] m_store_data_i,
    input  logic        dm_gnt_i,
    input  logic        dm_rvalid_i,
    input  logic [31:0] dm_rdata_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o
);

    dm_ctrl_state_t r_state;
    logic           r_req;
    logic           r_we;
    logic [3:0]     r_be;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_load_data;
    logic           r_load_valid;
    logic           r_misalign;

    logic           w_accept;
    logic           w_is_store;
    logic           w_misalign;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;

    // A request flagged as both load and store is treated as a load.
    assign w_is_store = m_is_store_i & ~m_is_load_i;
    assign w_accept   = rst_n_i & (r_state == DM_IDLE) & m_valid_i
                      & (m_is_load_i | m_is_store_i);

`ifdef DM_MISALIGN_TRAP_EN
    assign w_misalign = dm_misaligned(m_funct3_i, m_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    dm_store_fmt u_store_fmt (
        .i_is_store (w_is_store),
        .i_funct3   (m_funct3_i),
        .i_addr_lo  (m_addr_i[1:0]),
        .i_data     (m_store_data_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= DM_IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_load_data  <= 32'h0;
            r_load_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_misalign   <= 1'b0;
            case (r_state)
                DM_IDLE: begin
                    if (w_accept) begin
                        r_we    <= w_is_store;
                        r_be    <= w_be;
                        r_addr  <= {m_addr_i[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_state    <= DM_DONE;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= DM_REQ;
                        end
                    end
                end
                DM_REQ: begin
                    if (dm_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? DM_DONE : DM_WAIT;
                    end
                end
                DM_WAIT: begin
                    if (dm_rvalid_i) begin
                        r_load_data  <= dm_rdata_i;
                        r_load_valid <= 1'b1;
                        r_state      <= DM_DONE;
                    end
                end
                DM_DONE: begin
                    r_state <= DM_IDLE;
                end
                default: begin
                    r_state <= DM_IDLE;
                end
            endcase
        end
    end

    assign dm_req_o     = r_req;
    assign dm_we_o      = r_we;
    assign dm_be_o      = r_be;
    assign dm_addr_o    = r_addr;
    assign dm_wdata_o   = r_wdata;
    assign load_data_o  = r_load_data;
    assign load_valid_o = r_load_valid;
    assign misalign_o   = r_misalign;
    assign stall_o      = w_accept | (r_state == DM_REQ) | (r_state == DM_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ============================================================================
// Module  : tb_dm_access_ctrl
// Brief   : Randomised self-checking bench for dm_access_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dm_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        m_valid_i;
    logic        m_is_load_i;
    logic        m_is_store_i;
    logic [2:0]  m_funct3_i;
    logic [31:0] m_addr_i;
    logic [31:0] m_store_data_i;
    logic        dm_gnt_i;
    logic        dm_rvalid_i;
    logic [31:0] dm_rdata_i;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_load = 32'h0;

    always #5 clk_i = ~clk_i;

    dm_access_ctrl dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .m_valid_i      (m_valid_i),
        .m_is_load_i    (m_is_load_i),
        .m_is_store_i   (m_is_store_i),
        .m_funct3_i     (m_funct3_i),
        .m_addr_i       (m_addr_i),
        .m_store_data_i (m_store_data_i),
        .dm_gnt_i       (dm_gnt_i),
        .dm_rvalid_i    (dm_rvalid_i),
        .dm_rdata_i     (dm_rdata_i),
        .dm_req_o       (dm_req_o),
        .dm_we_o        (dm_we_o),
        .dm_be_o        (dm_be_o),
        .dm_addr_o      (dm_addr_o),
        .dm_wdata_o     (dm_wdata_o),
        .stall_o        (stall_o),
        .load_data_o    (load_data_o),
        .load_valid_o   (load_valid_o),
        .misalign_o     (misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(dm_req_o),     32'h0);
        chk({tag, "_we"},    32'(dm_we_o),      32'h0);
        chk({tag, "_be"},    32'(dm_be_o),      32'h0);
        chk({tag, "_addr"},  dm_addr_o,         32'h0);
        chk({tag, "_wdata"}, dm_wdata_o,        32'h0);
        chk({tag, "_ldata"}, load_data_o,       32'h0);
        chk({tag, "_lvld"},  32'(load_valid_o), 32'h0);
        chk({tag, "_mis"},   32'(misalign_o),   32'h0);
        chk({tag, "_stall"}, 32'(stall_o),      32'h0);
    endtask

    // One complete access, driven and checked cycle by cycle against the
    // access-level rules: alignment from the access size, lanes from the
    // byte offset, latency from the grant/response delays.
    task automatic access(input bit is_load, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata);
        int          size;
        bit          mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;
        size     = 1 << f3[1:0];
        mis      = (addr % size) != 0;
`ifndef DM_MISALIGN_TRAP_EN
        mis      = 1'b0;
`endif
        exp_addr = addr - (addr % 4);
        exp_wd   = data;
        exp_be   = 4'b1111;
        if (!is_load) begin
            if (size == 1) begin
                exp_be = 4'b0001 << (addr % 4);
                exp_wd = {4{data[7:0]}};
            end else if (size == 2) begin
                exp_be = 4'b0011 << (2 * ((addr % 4) / 2));
                exp_wd = {2{data[15:0]}};
            end
        end

        @(negedge clk_i);
        m_valid_i      = 1'b1;
        m_is_load_i    = is_load;
        m_is_store_i   = !is_load;
        m_funct3_i     = f3;
        m_addr_i       = addr;
        m_store_data_i = data;
        dm_gnt_i       = 1'b0;
        dm_rvalid_i    = 1'b0;
        #1;
        chk("accept_stall", 32'(stall_o), 32'h1);
        chk("accept_req",   32'(dm_req_o), 32'h0);
        @(negedge clk_i);
        m_valid_i      = 1'b0;
        m_funct3_i     = 3'($urandom);
        m_addr_i       = $urandom;
        m_store_data_i = $urandom;

        if (!mis) begin
            for (int k = 0; k <= gnt_dly; k++) begin
                dm_gnt_i    = (k == gnt_dly);
                dm_rvalid_i = 1'($urandom_range(0, 1));
                dm_rdata_i  = $urandom;
                #1;
                chk("req_req",   32'(dm_req_o), 32'h1);
                chk("req_stall", 32'(stall_o),  32'h1);
                chk("req_addr",  dm_addr_o,     exp_addr);
                chk("req_be",    32'(dm_be_o),  32'(exp_be));
                chk("req_we",    32'(dm_we_o),  32'(!is_load));
                if (!is_load) chk("req_wdata", dm_wdata_o, exp_wd);
                chk("req_ldata", load_data_o, last_load);
                @(negedge clk_i);
            end
            if (is_load) begin
                for (int k = 1; k <= rv_dly; k++) begin
                    dm_gnt_i    = 1'($urandom_range(0, 1));
                    dm_rvalid_i = (k == rv_dly);
                    dm_rdata_i  = (k == rv_dly) ? rdata : $urandom;
                    #1;
                    chk("wait_req",   32'(dm_req_o),     32'h0);
                    chk("wait_stall", 32'(stall_o),      32'h1);
                    chk("wait_lvld",  32'(load_valid_o), 32'h0);
                    @(negedge clk_i);
                end
                last_load = rdata;
            end
        end

        // DONE: a new request offered here must not be taken yet.
        dm_gnt_i     = 1'b0;
        dm_rvalid_i  = 1'($urandom_range(0, 1));
        dm_rdata_i   = $urandom;
        m_valid_i    = 1'($urandom_range(0, 1));
        m_is_load_i  = 1'($urandom_range(0, 1));
        m_is_store_i = !m_is_load_i;
        #1;
        chk("done_stall", 32'(stall_o),      32'h0);
        chk("done_req",   32'(dm_req_o),     32'h0);
        chk("done_lvld",  32'(load_valid_o), 32'(is_load && !mis));
        chk("done_mis",   32'(misalign_o),   32'(mis));
        chk("done_ldata", load_data_o,       last_load);
        @(negedge clk_i);
        m_valid_i   = 1'b0;
        dm_rvalid_i = 1'b0;
        #1;
        chk("idle_lvld",  32'(load_valid_o), 32'h0);
        chk("idle_mis",   32'(misalign_o),   32'h0);
        chk("idle_stall", 32'(stall_o),      32'h0);
        chk("idle_req",   32'(dm_req_o),     32'h0);
        chk("idle_ldata", load_data_o,       last_load);
    endtask

    initial begin
        rst_n_i        = 1'b0;
        m_valid_i      = 1'b0;
        m_is_load_i    = 1'b0;
        m_is_store_i   = 1'b0;
        m_funct3_i     = 3'b000;
        m_addr_i       = 32'h0;
        m_store_data_i = 32'h0;
        dm_gnt_i       = 1'b0;
        dm_rvalid_i    = 1'b0;
        dm_rdata_i     = 32'h0;
        #12;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        access(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
        access(1'b0, 3'b000, 32'h0000_0203, 32'h0000_005A, 0, 0, 32'h0);
        access(1'b1, 3'b001, 32'h0000_0402, 32'h0,         3, 2, 32'h8001_1234);
        access(1'b1, 3'b010, 32'h0000_0101, 32'h0,         0, 1, 32'hCAFE_F00D);
        access(1'b0, 3'b010, 32'h0000_0300, 32'h1234_5678, 1, 0, 32'h0);
        access(1'b1, 3'b010, 32'h0000_0304, 32'h0,         0, 1, 32'h0BAD_CAFE);

        // Reset while waiting for read data, then a stale response.
        @(negedge clk_i);
        m_valid_i    = 1'b1;
        m_is_load_i  = 1'b1;
        m_is_store_i = 1'b0;
        m_funct3_i   = 3'b010;
        m_addr_i     = 32'h0000_0500;
        @(negedge clk_i);
        m_valid_i = 1'b0;
        dm_gnt_i  = 1'b1;
        @(negedge clk_i);
        dm_gnt_i = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(stall_o), 32'h1);
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk_i);
        rst_n_i     = 1'b1;
        dm_rvalid_i = 1'b1;
        dm_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk_i);
        dm_rvalid_i = 1'b0;
        #1;
        chk_all_zero("rst_late_rvalid");
        last_load = 32'h0;

        for (int n = 0; n < 300; n++) begin
            bit          ld;
            logic [2:0]  f3;
            int          pick;
            ld   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, ld ? 4 : 2);
            case (pick)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            access(ld, f3, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(1, 4), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
